// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the data-memory responder.
//               byte_t      - one byte lane of a 32-bit word
//               mem_state_t - responder transaction state
//               LANES       - byte lanes per word
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int LANES = 4;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_byte_bank.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_bank
// Description : One byte lane of the responder storage. DEPTH_WORDS x 8,
//               written on the clock edge, read combinationally so that the
//               controller can capture the addressed byte into its own output
//               register on the same edge that completes a transaction.
// Ports       : clk   - clock, write on posedge
//               we    - lane write enable
//               addr  - word index
//               wdata - byte to store
//               rdata - byte currently stored at addr
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_bank
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  byte_t                wdata,
    output byte_t                rdata
);

    // Storage is intentionally not reset: contents survive a controller reset.
    byte_t r_mem [0:DEPTH_WORDS-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule : mem_byte_bank
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side responder for the core data port. Word-organised,
//               byte-laned storage serviced one request at a time with a fixed
//               LATENCY; completion is a one-cycle mem_ready pulse.
// Ports       : clk          - clock, all logic on posedge
//               rst_b        - synchronous reset, active HIGH
//               mem_req      - request strobe, honoured only when idle
//               mem_addr     - byte address of the word
//               mem_write_en - 1 = write, 0 = read
//               mem_byte_en  - per-lane write enable
//               mem_data_in  - write data, lane 0 = lowest byte address
//               mem_data_out - registered read data
//               mem_ready    - one-cycle completion pulse
//               mem_err      - misaligned / out-of-range, valid with mem_ready
//               mem_busy     - a transaction is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              mem_req,
    input  logic [31:0]       mem_addr,
    input  logic              mem_write_en,
    input  logic [LANES-1:0]  mem_byte_en,
    input  byte_t [0:LANES-1] mem_data_in,
    output byte_t [0:LANES-1] mem_data_out,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              mem_busy
);

    localparam int          ADDR_BITS  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  c_cnt_load = 4'(LATENCY - 1);
    localparam logic [31:0] c_depth    = 32'(DEPTH_WORDS);

    // ------------------------------------------------------------------------
    // State and request latches
    // ------------------------------------------------------------------------
    mem_state_t           r_state;
    mem_state_t           w_next_state;
    logic [3:0]           r_cnt;

    logic                 r_we;
    logic                 r_err;
    logic [LANES-1:0]     r_be;
    byte_t [0:LANES-1]    r_wdata;
    logic [ADDR_BITS-1:0] r_word;
    logic                 r_resp_err;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                 w_accept;
    logic                 w_req_err;
    logic                 w_enter_resp;
    logic                 w_cur_we;
    logic                 w_cur_err;
    logic [LANES-1:0]     w_cur_be;
    byte_t [0:LANES-1]    w_cur_wdata;
    logic [ADDR_BITS-1:0] w_cur_word;
    logic [LANES-1:0]     w_lane_we;
    byte_t [0:LANES-1]    w_rdata;

    assign w_accept = (r_state == IDLE) && mem_req;

    // Misaligned, or word index beyond the populated storage.
    assign w_req_err = (mem_addr[1:0] != 2'b00) ||
                       ({2'b00, mem_addr[31:2]} >= c_depth);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_next_state = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                // <= 1 rather than == 1 so a corrupted count cannot stall forever.
                if (r_cnt <= 4'd1) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The edge that moves into RESP is where storage and read data update.
    assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);

    // ------------------------------------------------------------------------
    // Latency counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_cnt_load;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Request latches: frozen from acceptance until the response
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_word  <= '0;
        end else if (w_accept) begin
            r_we    <= mem_write_en;
            r_err   <= w_req_err;
            r_be    <= mem_byte_en;
            r_wdata <= mem_data_in;
            r_word  <= mem_addr[ADDR_BITS+1:2];
        end
    end

    // ------------------------------------------------------------------------
    // Transaction view used at completion. With LATENCY==1 the request is
    // accepted and completed on the same edge, so the latches are not yet
    // loaded and the live inputs must be used instead.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cur_we    = r_we;
        w_cur_err   = r_err;
        w_cur_be    = r_be;
        w_cur_wdata = r_wdata;
        w_cur_word  = r_word;
        if (r_state == IDLE) begin
            w_cur_we    = mem_write_en;
            w_cur_err   = w_req_err;
            w_cur_be    = mem_byte_en;
            w_cur_wdata = mem_data_in;
            w_cur_word  = mem_addr[ADDR_BITS+1:2];
        end
    end

    // Reset on the completing edge wins, so a pending write is dropped.
    assign w_lane_we = {LANES{w_enter_resp && !rst_b && w_cur_we && !w_cur_err}} & w_cur_be;

    // ------------------------------------------------------------------------
    // Storage: one byte bank per lane
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        mem_byte_bank #(
            .DEPTH_WORDS (DEPTH_WORDS),
            .ADDR_BITS   (ADDR_BITS)
        ) u_bank (
            .clk   (clk),
            .we    (w_lane_we[gi]),
            .addr  (w_cur_word),
            .wdata (w_cur_wdata[gi]),
            .rdata (w_rdata[gi])
        );
    end

    // ------------------------------------------------------------------------
    // Response registers. Read data only changes on a read response; an
    // erroring read returns zero, writes leave the last read value visible.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            mem_data_out <= '0;
            r_resp_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_resp_err <= w_cur_err;
            if (!w_cur_we) begin
                mem_data_out <= w_cur_err ? '0 : w_rdata;
            end
        end
    end

    assign mem_ready = (r_state == RESP);
    assign mem_err   = (r_state == RESP) && r_resp_err;
    assign mem_busy  = (r_state != IDLE);

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed bench for data_mem_responder. Two instances run side
//               by side (LATENCY 4 and LATENCY 1). A transaction-level model
//               predicts ready/busy/err/data every cycle; directed sequences
//               add hand-computed literal expectations.
//               Lane-ordered words: 32'hEFBEADDE means lane0=EF .. lane3=DE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst  [2];
    logic              req  [2];
    logic              we   [2];
    logic [31:0]       addr [2];
    logic [3:0]        be   [2];
    logic [0:3][7:0]   din  [2];
    logic [0:3][7:0]   dout [2];
    logic              rdy  [2];
    logic              err  [2];
    logic              busy [2];

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst_b(rst[0]), .mem_req(req[0]), .mem_addr(addr[0]),
        .mem_write_en(we[0]), .mem_byte_en(be[0]), .mem_data_in(din[0]),
        .mem_data_out(dout[0]), .mem_ready(rdy[0]), .mem_err(err[0]), .mem_busy(busy[0])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_b(rst[1]), .mem_req(req[1]), .mem_addr(addr[1]),
        .mem_write_en(we[1]), .mem_byte_en(be[1]), .mem_data_in(din[1]),
        .mem_data_out(dout[1]), .mem_ready(rdy[1]), .mem_err(err[1]), .mem_busy(busy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: waited too long, event never seen (cycle %0d)", nm, cyc);
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model: one outstanding request, completion LAT edges
    // after acceptance, byte-addressed memory.
    // ------------------------------------------------------------------------
    int              LAT    [2] = '{4, 1};
    bit              m_pend [2] = '{1'b0, 1'b0};
    bit              m_rdy  [2] = '{1'b0, 1'b0};
    bit              m_err  [2] = '{1'b0, 1'b0};
    int              m_due  [2] = '{0, 0};
    int              m_acc  [2] = '{0, 0};
    logic            m_we   [2];
    logic [31:0]     m_a    [2];
    logic [3:0]      m_be   [2];
    logic [0:3][7:0] m_wd   [2];
    logic [0:3][7:0] m_out  [2] = '{32'h0, 32'h0};
    logic [7:0]      mmem   [int];

    function automatic int key(input int d, input logic [31:0] a, input int lane);
        return d * 32'h10000 + int'(a[15:0]) + lane;
    endfunction

    task automatic mcomplete(input int d);
        bit e;
        e = (m_a[d][1:0] != 2'b00) || (m_a[d] >= 32'h1000);
        m_pend[d] = 1'b0;
        m_rdy[d]  = 1'b1;
        m_err[d]  = e;
        if (!m_we[d]) begin
            for (int i = 0; i < 4; i++) begin
                if (e || !mmem.exists(key(d, m_a[d], i))) m_out[d][i] = 8'h00;
                else                                      m_out[d][i] = mmem[key(d, m_a[d], i)];
            end
        end else if (!e) begin
            for (int i = 0; i < 4; i++)
                if (m_be[d][i]) mmem[key(d, m_a[d], i)] = m_wd[d][i];
        end
    endtask

    task automatic mstep(input int d);
        if (rst[d]) begin
            m_pend[d] = 1'b0;
            m_rdy[d]  = 1'b0;
            m_err[d]  = 1'b0;
            m_out[d]  = '0;
        end else if (m_rdy[d]) begin
            m_rdy[d] = 1'b0;
            m_err[d] = 1'b0;
        end else if (m_pend[d]) begin
            if (cyc == m_due[d]) mcomplete(d);
        end else if (req[d]) begin
            m_we[d] = we[d];
            m_a[d]  = addr[d];
            m_be[d] = be[d];
            m_wd[d] = din[d];
            m_acc[d]++;
            m_due[d]  = cyc + LAT[d] - 1;
            m_pend[d] = 1'b1;
            if (cyc == m_due[d]) mcomplete(d);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) mstep(d);
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("ready[%0d]", d), {31'b0, rdy[d]}, {31'b0, m_rdy[d]});
                    chk($sformatf("busy[%0d]", d), {31'b0, busy[d]}, {31'b0, m_pend[d] | m_rdy[d]});
                    if (m_rdy[d]) chk($sformatf("err[%0d]", d), {31'b0, err[d]}, {31'b0, m_err[d]});
                    chk($sformatf("dout[%0d]", d), dout[d], m_out[d]);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic wait_rdy(input int d, output int t, output logic [31:0] rd, output logic re);
        t  = -1;
        rd = 'x;
        re = 1'bx;
        for (int i = 0; i < 20 && t < 0; i++) begin
            if (rdy[d]) begin
                t  = cyc;
                rd = dout[d];
                re = err[d];
            end else begin
                @(negedge clk);
            end
        end
        if (t < 0) fail_bound($sformatf("ready_wait[%0d]", d));
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] data, output int lat, output logic [31:0] rd,
                       output logic re);
        int acc0, t_req, t_rdy;
        @(negedge clk);
        acc0    = m_acc[d];
        req[d]  = 1'b1;
        we[d]   = w;
        addr[d] = a;
        be[d]   = b;
        din[d]  = data;
        t_req   = cyc;
        lat     = -1;
        rd      = 'x;
        re      = 1'bx;
        for (int i = 0; i < 20 && m_acc[d] == acc0; i++) begin
            t_req = cyc;
            @(negedge clk);
        end
        req[d] = 1'b0;
        if (m_acc[d] == acc0) begin
            fail_bound($sformatf("accept_wait[%0d]", d));
            return;
        end
        wait_rdy(d, t_rdy, rd, re);
        if (t_rdy >= 0) lat = t_rdy - t_req;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequences
    // ------------------------------------------------------------------------
    initial begin
        int          lat, r1, r2, acc0, cnt;
        logic [31:0] rd;
        logic        re;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
            addr[d] = '0; be[d] = '0; din[d] = '0;
        end

        // 1. reset held for two edges
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", {31'b0, rdy[d]}, 32'h0);
            chk("reset_busy", {31'b0, busy[d]}, 32'h0);
            chk("reset_dout", dout[d], 32'h0);
        end

        // 2./3. full write, read back, partial write, read back
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 32'h10, 4'hF, 32'hEFBEADDE, lat, rd, re);
            chk("write_latency", lat, (d == 0) ? 32'd4 : 32'd1);
            chk("write_keeps_dout", dout[d], 32'h0);
            txn(d, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, re);
            chk("read_latency", lat, (d == 0) ? 32'd4 : 32'd1);
            chk("read_full", rd, 32'hEFBEADDE);
            chk("read_full_err", {31'b0, re}, 32'h0);
            txn(d, 1'b1, 32'h10, 4'b0010, 32'h00550000, lat, rd, re);
            txn(d, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, re);
            chk("read_partial", rd, 32'hEF55ADDE);
        end

        // second word for the hold test
        txn(0, 1'b1, 32'h14, 4'hF, 32'h44332211, lat, rd, re);

        // 4. request held through BUSY/RESP with different fields
        @(negedge clk);
        acc0    = m_acc[0];
        req[0]  = 1'b1;
        we[0]   = 1'b0;
        addr[0] = 32'h10;
        be[0]   = 4'h0;
        for (int i = 0; i < 20 && m_acc[0] == acc0; i++) @(negedge clk);
        if (m_acc[0] == acc0) fail_bound("hold_accept1");
        addr[0] = 32'h14;
        din[0]  = 32'hFFFFFFFF;
        wait_rdy(0, r1, rd, re);
        chk("hold_first_frozen", rd, 32'hEF55ADDE);
        @(negedge clk);
        for (int i = 0; i < 20 && m_acc[0] == acc0 + 1; i++) @(negedge clk);
        if (m_acc[0] != acc0 + 2) fail_bound("hold_accept2");
        req[0] = 1'b0;
        wait_rdy(0, r2, rd, re);
        chk("hold_gap", r2 - r1, 32'd5);
        chk("hold_second_data", rd, 32'h44332211);
        @(negedge clk);

        // 5. error responses
        txn(0, 1'b0, 32'h13, 4'h0, 32'h0, lat, rd, re);
        chk("misaligned_err", {31'b0, re}, 32'h1);
        chk("misaligned_data", rd, 32'h0);
        txn(0, 1'b0, 32'h1000, 4'h0, 32'h0, lat, rd, re);
        chk("range_err", {31'b0, re}, 32'h1);
        chk("range_data", rd, 32'h0);
        txn(0, 1'b1, 32'h12, 4'hF, 32'hFFFFFFFF, lat, rd, re);
        chk("bad_write_err", {31'b0, re}, 32'h1);
        txn(0, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, re);
        chk("after_err_data", rd, 32'hEF55ADDE);
        chk("after_err_ok", {31'b0, re}, 32'h0);
        txn(0, 1'b1, 32'hFFC, 4'hF, 32'hA1B2C3D4, lat, rd, re);
        txn(0, 1'b0, 32'hFFC, 4'h0, 32'h0, lat, rd, re);
        chk("last_word_data", rd, 32'hA1B2C3D4);
        chk("last_word_err", {31'b0, re}, 32'h0);

        // 6a. reset during BUSY cycle 2 drops the write (LATENCY 4)
        @(negedge clk);
        acc0    = m_acc[0];
        req[0]  = 1'b1;
        we[0]   = 1'b1;
        addr[0] = 32'h10;
        be[0]   = 4'hF;
        din[0]  = 32'h0;
        for (int i = 0; i < 20 && m_acc[0] == acc0; i++) @(negedge clk);
        req[0] = 1'b0;
        if (m_acc[0] == acc0) fail_bound("rst_accept");
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (rdy[0]) cnt++;
            @(negedge clk);
        end
        chk("rst_no_ready4", cnt, 32'd0);
        txn(0, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, re);
        chk("rst_write_dropped4", rd, 32'hEF55ADDE);

        // 6b. LATENCY 1: reset coincident with the write request
        @(negedge clk);
        req[1]  = 1'b1;
        we[1]   = 1'b1;
        addr[1] = 32'h10;
        be[1]   = 4'hF;
        din[1]  = 32'h0;
        rst[1]  = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        rst[1] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (rdy[1]) cnt++;
            @(negedge clk);
        end
        chk("rst_no_ready1", cnt, 32'd0);
        txn(1, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, re);
        chk("rst_write_dropped1", rd, 32'hEF55ADDE);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire
